// File: rtl/nco_pkg.sv
// Shared NCO definitions: sweep controller state type and default accumulator width.
package nco_pkg;

  localparam int unsigned ACC_W_DEFAULT = 32;
  localparam int unsigned SAW_W         = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_HOLD  = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/phase_acc.sv
// Phase accumulator: adds i_inc on each enabled clock, wrapping modulo 2^W.
module phase_acc #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_inc,
  output logic [W-1:0] o_acc
);

  logic [W-1:0] r_acc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + i_inc;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/saw_sweep.sv
// Linear frequency sweep around a phase accumulator; o_saw is the accumulator's top 16 bits.
module saw_sweep
  import nco_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int OUT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [ACC_W-1:0] i_fcw_start,
  input  logic [ACC_W-1:0] i_fcw_stop,
  input  logic [ACC_W-1:0] i_fcw_step,
  input  logic [15:0]      i_dwell,
  output logic [15:0]      o_saw,
  output logic             o_busy,
  output logic             o_done
);

  sweep_state_t r_state;
  sweep_state_t w_state_nx;

  logic [ACC_W-1:0] r_fcw;
  logic [ACC_W-1:0] r_stop;
  logic [ACC_W-1:0] r_step;
  logic [15:0]      r_dwell;
  logic [15:0]      r_dwell_cnt;
  logic             r_done;

  logic             w_params_ok;
  logic             w_start_ok;
  logic             w_dwell_hit;
  logic [ACC_W:0]   w_next_fcw;
  logic             w_reach_stop;
  logic             w_sweep_end;
  logic             w_hold_entry;
  logic [ACC_W-1:0] w_inc;
  logic [ACC_W-1:0] w_acc;

  assign w_params_ok  = (i_fcw_stop > i_fcw_start) && (i_fcw_step != '0);
  assign w_start_ok   = i_start && !i_abort && (r_state != ST_SWEEP);
  assign w_dwell_hit  = (r_dwell_cnt == r_dwell);
  // One extra bit so a step past 2^ACC_W still compares as reaching stop.
  assign w_next_fcw   = {1'b0, r_fcw} + {1'b0, r_step};
  assign w_reach_stop = (w_next_fcw >= {1'b0, r_stop});
  assign w_sweep_end  = (r_state == ST_SWEEP) && i_tick && w_dwell_hit && w_reach_stop;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_done  <= w_hold_entry;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    if (i_abort) begin
      w_state_nx = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (i_start) begin
            w_state_nx = w_params_ok ? ST_SWEEP : ST_HOLD;
          end
        end
        ST_SWEEP: begin
          if (w_sweep_end) begin
            w_state_nx = ST_HOLD;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    o_busy       = (r_state == ST_SWEEP);
    w_hold_entry = !i_abort && ((w_start_ok && !w_params_ok) || w_sweep_end);
  end

  // Tuning word, dwell counter and latched sweep parameters
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fcw       <= '0;
      r_stop      <= '0;
      r_step      <= '0;
      r_dwell     <= '0;
      r_dwell_cnt <= '0;
    end else if (w_start_ok) begin
      if (w_params_ok) begin
        r_stop      <= i_fcw_stop;
        r_step      <= i_fcw_step;
        r_dwell     <= i_dwell;
        r_fcw       <= i_fcw_start;
        r_dwell_cnt <= '0;
      end else begin
        r_fcw <= i_fcw_stop;
      end
    end else if (!i_abort && (r_state == ST_SWEEP) && i_tick) begin
      if (w_dwell_hit) begin
        r_dwell_cnt <= '0;
        r_fcw       <= w_reach_stop ? r_stop : w_next_fcw[ACC_W-1:0];
      end else begin
        r_dwell_cnt <= r_dwell_cnt + 16'd1;
      end
    end
  end

  // The adder sees the registered fcw, so a step takes effect on the following tick.
  assign w_inc = (r_state == ST_IDLE) ? i_fcw_start : r_fcw;

  phase_acc #(
    .W (ACC_W)
  ) u_phase_acc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_tick),
    .i_inc   (w_inc),
    .o_acc   (w_acc)
  );

  assign o_saw  = w_acc[ACC_W-1 -: OUT_W];
  assign o_done = r_done;

endmodule

// File: tb/tb_saw_sweep.sv
// Self-checking bench for saw_sweep: tone/sweep model compared every cycle plus literal anchors.
module tb_saw_sweep;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        start;
  logic        abort;
  logic [31:0] fcw_start;
  logic [31:0] fcw_stop;
  logic [31:0] fcw_step;
  logic [15:0] dwell;
  logic [15:0] saw;
  logic        busy;
  logic        done;

  int unsigned n_total;
  int unsigned n_pass;

  saw_sweep #(
    .ACC_W (32)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_tick      (tick),
    .i_start     (start),
    .i_abort     (abort),
    .i_fcw_start (fcw_start),
    .i_fcw_stop  (fcw_stop),
    .i_fcw_step  (fcw_step),
    .i_dwell     (dwell),
    .o_saw       (saw),
    .o_busy      (busy),
    .o_done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: the current tone is held for a number of ticks, then advances by the step.
  // mode: 0 idle tone, 1 sweeping, 2 holding at the stop tone.
  logic [31:0] m_acc;
  int          m_mode;
  longint      m_tone;
  longint      m_stop;
  longint      m_step;
  int          m_ticks_per_tone;
  int          m_ticks_left;
  logic        m_done;
  logic        m_valid;

  task automatic model_edge();
    logic done_nx;
    longint nt;
    done_nx = 1'b0;
    if (!rst_n) begin
      m_acc = '0; m_mode = 0; m_tone = 0; m_ticks_left = 0;
    end else begin
      if (tick) m_acc = m_acc + ((m_mode == 0) ? fcw_start : 32'(m_tone));
      if (abort) begin
        m_mode = 0;
      end else if (start && m_mode != 1) begin
        if (fcw_stop > fcw_start && fcw_step != 0) begin
          m_mode = 1; m_tone = fcw_start; m_stop = fcw_stop; m_step = fcw_step;
          m_ticks_per_tone = int'(dwell) + 1;
          m_ticks_left = m_ticks_per_tone;
        end else begin
          m_mode = 2; m_tone = fcw_stop; done_nx = 1'b1;
        end
      end else if (m_mode == 1 && tick) begin
        m_ticks_left--;
        if (m_ticks_left == 0) begin
          nt = m_tone + m_step;
          if (nt >= m_stop) begin
            m_tone = m_stop; m_mode = 2; done_nx = 1'b1;
          end else begin
            m_tone = nt; m_ticks_left = m_ticks_per_tone;
          end
        end
      end
    end
    m_done = done_nx;
  endtask

  task automatic cyc(input logic t, input logic s, input logic a);
    tick = t; start = s; abort = a;
    @(posedge clk);
    model_edge();
    m_valid = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("saw", {16'h0, saw}, {16'h0, m_acc[31:16]});
      check("busy", {31'h0, busy}, {31'h0, m_mode == 1});
      check("done", {31'h0, done}, {31'h0, m_done});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned busy_ticks;
    int unsigned done_seen;
    int unsigned idle_seen;
    n_total = 0; n_pass = 0; m_valid = 1'b0;
    rst_n = 1'b0; tick = 1'b1; start = 1'b0; abort = 1'b0;
    fcw_start = 32'h0100_0000; fcw_stop = '0; fcw_step = '0; dwell = '0;

    // Reset with tick high
    do_reset();
    check("rst_saw", {16'h0, saw}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);

    // IDLE tone: +0x0100 per tick, wraps at tick 256
    cyc(1, 0, 0);
    check("tone_t1", {16'h0, saw}, 32'h0100);
    for (int i = 2; i <= 255; i++) cyc(1, 0, 0);
    check("tone_t255", {16'h0, saw}, 32'hFF00);
    cyc(1, 0, 0);
    check("tone_wrap", {16'h0, saw}, 32'h0000);

    // Dwell 0 sweep from a zero phase; start issued without a tick
    do_reset();
    fcw_start = 32'h0001_0000; fcw_stop = 32'h0005_0000; fcw_step = 32'h0001_0000; dwell = 16'd0;
    cyc(0, 1, 0);
    busy_ticks = 0; done_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      if (busy) busy_ticks++;
      cyc(1, 0, 0);
      if (done) done_seen++;
      case (i)
        1: check("sw0_t1", {16'h0, saw}, 32'h0001);
        2: check("sw0_t2", {16'h0, saw}, 32'h0003);
        3: check("sw0_t3", {16'h0, saw}, 32'h0006);
        4: check("sw0_t4", {16'h0, saw}, 32'h000A);
        5: check("sw0_t5", {16'h0, saw}, 32'h000F);
        6: check("sw0_t6", {16'h0, saw}, 32'h0014);
        default: ;
      endcase
    end
    check("sw0_busy_ticks", busy_ticks, 32'd4);
    check("sw0_done_count", done_seen, 32'd1);

    // HOLD with sparse ticks keeps the stop tone
    for (int i = 0; i < 8; i++) cyc(1'(i % 3 == 0), 0, 0);

    // Dwell 2 sweep: each tone for 3 ticks, HOLD after 12
    do_reset();
    dwell = 16'd2;
    cyc(0, 1, 0);
    busy_ticks = 0;
    for (int i = 0; i < 50 && busy; i++) begin
      busy_ticks++;
      cyc(1, 0, 0);
    end
    check("sw2_busy_ticks", busy_ticks, 32'd12);
    check("sw2_saw", {16'h0, saw}, 32'h001E);
    check("sw2_done", {31'h0, done}, 32'h1);
    cyc(1, 1, 0);  // restart from HOLD
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    cyc(1, 1, 0);  // ignored while sweeping
    check("sw2_start_ignored", {31'h0, busy}, 32'h1);

    // Abort mid-sweep, with the tick
    cyc(1, 0, 1);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0);
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 32'd0);

    // Start together with abort stays IDLE; also from SWEEP without a tick
    cyc(1, 1, 1);
    check("startabort_busy", {31'h0, busy}, 32'h0);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    cyc(0, 1, 1);
    check("abort_notick", {31'h0, busy}, 32'h0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0);

    // Invalid parameters: stop == start, then step == 0 from HOLD
    fcw_stop = fcw_start;
    busy_ticks = 0; done_seen = 0;
    cyc(1, 1, 0);
    check("inv_done", {31'h0, done}, 32'h1);
    for (int i = 0; i < 6; i++) begin
      if (busy) busy_ticks++;
      if (done) done_seen++;
      cyc(1, 0, 0);
    end
    fcw_stop = 32'h0005_0000; fcw_step = 32'h0;
    cyc(1, 1, 0);
    if (busy) busy_ticks++;
    if (done) done_seen++;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 0);
      if (busy) busy_ticks++;
    end
    check("inv_busy_never", busy_ticks, 32'd0);
    check("inv_done_count", done_seen, 32'd2);
    cyc(1, 0, 1);

    // Idle again with a random tick pattern and changing tone
    idle_seen = 0;
    for (int i = 0; i < 40; i++) begin
      fcw_start = $urandom;
      cyc(1'($urandom_range(0, 1)), 0, 0);
      if (!busy) idle_seen++;
    end
    check("idle_random", idle_seen, 32'd40);

    @(posedge clk);
    #1;
    m_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
